rps_match_engine: RTL and testbench
===================================

// Module: rps_match_engine
// PURPOSE
//  Parametrised rock-paper-scissors match controller: one round per play press, judged against a computer move.
//  Computer move comes from a free-running LFSR (mode 0) or an adaptive first-order history predictor (mode 1).
//  Keeps saturating scores, declares a match winner at WIN_TARGET, feeds HEX/LEDR display logic in the board top level.
// PARAMETERS
//  SCORE_W     8      width of each score counter
//  WIN_TARGET  5      first to this score wins the match; must satisfy 1 <= WIN_TARGET <= 2**SCORE_W-1
//  CNT_W       4      width of each predictor history counter
//  LFSR_SEED   16'hACE1  LFSR reset value; must be nonzero
// PORTS
//  CLOCK_50      in   1        system clock
//  reset         in   1        synchronous, active-low reset
//  play          in   1        level request (SW); a round starts on its rising edge
//  user_move     in   2        00 rock, 01 scissors, 10 paper, 11 invalid
//  mode          in   1        0 = random opponent, 1 = adaptive opponent; sampled on play rising edge
//  new_match     in   1        1-cycle pulse: clear scores and flags, keep predictor history
//  com_move      out  2        computer move of the last round
//  user_score    out  SCORE_W  user score
//  com_score     out  SCORE_W  computer score
//  uwin/cwin/draw out 1 each   result of the last judged round, held until the next round
//  invalid       out  1        last press carried user_move=11
//  result_valid  out  1        1-cycle pulse when a round is judged
//  match_over    out  1        a score has reached WIN_TARGET
//  match_winner  out  1        0 = user, 1 = computer; valid while match_over=1
//  busy          out  1        state != IDLE
// BEHAVIOUR
//  - Reset (reset=0 at posedge): all outputs 0, state IDLE, play_q=0, LFSR=LFSR_SEED, history counters 0, prev_valid=0.
//  - play_rise = play & ~play_q; play_q is registered every cycle.
//  - Rules: rock beats scissors, scissors beats paper, paper beats rock, equal moves draw.
//  - FSM states:
//    IDLE: on play_rise with user_move!=11, latch move and mode -> DECIDE.
//          On play_rise with user_move=11: invalid=1, uwin/cwin/draw=0, no score change -> WAIT_REL.
//    DECIDE: com_move <= chosen move -> JUDGE.
//    JUDGE: set exactly one of uwin/cwin/draw, invalid=0, increment the winner's score, result_valid=1.
//           Update history, prev_move <= user move, prev_valid=1.
//           -> OVER if the incremented score == WIN_TARGET, else WAIT_REL.
//    WAIT_REL: wait for play=0 -> IDLE. Holding play high never starts a second round.
//    OVER: match_over=1, match_winner latched; play is ignored.
//  - result_valid rises exactly 2 cycles after the cycle play_rise is seen in IDLE.
//  - new_match: clears scores, uwin/cwin/draw/invalid/match_over/match_winner; state -> WAIT_REL (or IDLE if play=0).
//    It is honoured in any state and has priority over JUDGE updates in the same cycle.
//  - Scores never wrap: increments stop at WIN_TARGET.
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle.
//    rand = lfsr[1:0]; if rand==11 then rand = {1'b0, lfsr[2]}.
//  - Adaptive choice: row = hist[prev_move], three counters.
//    Predicted = argmax of the row, ties resolved to the lower encoding.
//    com = beater(predicted): rock->paper, scissors->rock, paper->scissors.
//    Falls back to rand if prev_valid=0 or the row is all zero.
//  - History update: hist[prev][cur] += 1 when prev_valid. If it would overflow 2**CNT_W-1, halve all three row counters first, then add 1.
//  - Invalid presses do not touch history or prev_move.
// STRUCTURE
//  - rps_pkg: move localparams (ROCK, SCISSORS, PAPER, INVALID), state encoding, functions beats(a,b) and beater(m).
//  - Sub-module rps_predictor: history table, saturation/halving, argmax, beater output.
//    Ports: clk, reset, upd, prev, cur, prev_valid, rand, pred_move.
//  - The LFSR, FSM and scoring live in rps_match_engine.
// TESTING
//  1. Reset, then play rise with user_move=00, mode=0, LFSR forced so com=01
//     -> 2 cycles later result_valid=1, uwin=1, user_score=1.
//  2. Hold play high 20 cycles after a round -> exactly one result_valid pulse, scores change once.
//  3. user_move=11 press -> invalid=1, no result_valid, scores/history unchanged; next valid press clears invalid.
//  4. mode=1, user plays rock 6 times in a row -> from round 3 onward com_move=10 and cwin=1.
//  5. WIN_TARGET=3, computer wins 3 rounds -> match_over=1, match_winner=1, com_score=3; further presses ignored.
//     Then new_match -> scores 0, match_over=0.
//  6. reset=0 asserted mid-DECIDE, and CNT_W=2 with 4 same-pair updates -> all outputs 0;
//     the row halves (3 -> 1, then +1 = 2).

Source files
------------

// File: rtl/rps_pkg.sv
// rtl/rps_pkg.sv - move encodings, FSM states and game-rule helpers
package rps_pkg;

    localparam logic [1:0] ROCK     = 2'b00;
    localparam logic [1:0] SCISSORS = 2'b01;
    localparam logic [1:0] PAPER    = 2'b10;
    localparam logic [1:0] INVALID  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_JUDGE,
        S_WAIT_REL,
        S_OVER
    } state_t;

    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return ((a == ROCK)     && (b == SCISSORS)) ||
               ((a == SCISSORS) && (b == PAPER))    ||
               ((a == PAPER)    && (b == ROCK));
    endfunction

    function automatic logic [1:0] beater(input logic [1:0] m);
        logic [1:0] r;
        case (m)
            ROCK:     r = PAPER;
            SCISSORS: r = ROCK;
            PAPER:    r = SCISSORS;
            default:  r = ROCK;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rps_predictor.sv
// rtl/rps_predictor.sv - first-order move history table with argmax counter-move
module rps_predictor
    import rps_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       upd,
    input  logic [1:0] prev,
    input  logic [1:0] cur,
    input  logic       prev_valid,
    input  logic [1:0] rand_move,
    output logic [1:0] pred_move
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] hist [3][3];
    logic [CNT_W-1:0] best_cnt;
    logic [1:0]       best;

    // A saturated cell halves its whole row so relative weights survive.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    hist[i][j] <= '0;
                end
            end
        end else if (upd && prev_valid) begin
            if (hist[prev][cur] == CNT_MAX) begin
                for (int j = 0; j < 3; j++) begin
                    hist[prev][j] <= (j == int'(cur)) ? ((hist[prev][j] >> 1) + 1'b1)
                                                      : (hist[prev][j] >> 1);
                end
            end else begin
                hist[prev][cur] <= hist[prev][cur] + 1'b1;
            end
        end
    end

    // Strict '>' keeps the lowest encoding on ties.
    always_comb begin
        best     = ROCK;
        best_cnt = hist[prev][0];
        for (int j = 1; j < 3; j++) begin
            if (hist[prev][j] > best_cnt) begin
                best_cnt = hist[prev][j];
                best     = 2'(j);
            end
        end
        if (!prev_valid || (best_cnt == '0)) begin
            pred_move = rand_move;
        end else begin
            pred_move = beater(best);
        end
    end

endmodule

// File: rtl/rps_match_engine.sv
// rtl/rps_match_engine.sv - round FSM, LFSR opponent and saturating match scoring
module rps_match_engine
    import rps_pkg::*;
#(
    parameter int          SCORE_W    = 8,
    parameter int          WIN_TARGET = 5,
    parameter int          CNT_W      = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               play,
    input  logic [1:0]         user_move,
    input  logic               mode,
    input  logic               new_match,
    output logic [1:0]         com_move,
    output logic [SCORE_W-1:0] user_score,
    output logic [SCORE_W-1:0] com_score,
    output logic               uwin,
    output logic               cwin,
    output logic               draw,
    output logic               invalid,
    output logic               result_valid,
    output logic               match_over,
    output logic               match_winner,
    output logic               busy
);

    localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);

    state_t             state;
    state_t             state_nx;
    logic               play_q;
    logic               play_rise;
    logic [15:0]        lfsr;
    logic [1:0]         rand_move;
    logic [1:0]         pred_move;
    logic [1:0]         move_q;
    logic               mode_q;
    logic [1:0]         prev_move;
    logic               prev_valid;
    logic               u_wins;
    logic               c_wins;
    logic               tie;
    logic [SCORE_W-1:0] user_nx;
    logic [SCORE_W-1:0] com_nx;
    logic               reach;
    logic               judge_upd;

    assign play_rise = play & ~play_q;
    assign busy      = (state != S_IDLE);
    assign rand_move = (lfsr[1:0] == 2'b11) ? {1'b0, lfsr[2]} : lfsr[1:0];

    assign u_wins  = beats(move_q, com_move);
    assign c_wins  = beats(com_move, move_q);
    assign tie     = (move_q == com_move);
    assign user_nx = (u_wins && (user_score < TARGET)) ? user_score + 1'b1 : user_score;
    assign com_nx  = (c_wins && (com_score < TARGET)) ? com_score + 1'b1 : com_score;
    assign reach   = (u_wins && (user_nx == TARGET)) || (c_wins && (com_nx == TARGET));

    // A same-cycle new_match discards the judgement, history included.
    assign judge_upd = (state == S_JUDGE) && !new_match;

    rps_predictor #(
        .CNT_W(CNT_W)
    ) u_pred (
        .clk       (CLOCK_50),
        .reset     (reset),
        .upd       (judge_upd),
        .prev      (prev_move),
        .cur       (move_q),
        .prev_valid(prev_valid),
        .rand_move (rand_move),
        .pred_move (pred_move)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (new_match) begin
            state_nx = play ? S_WAIT_REL : S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (play_rise) begin
                        state_nx = (user_move == INVALID) ? S_WAIT_REL : S_DECIDE;
                    end
                end
                S_DECIDE:   state_nx = S_JUDGE;
                S_JUDGE:    state_nx = reach ? S_OVER : S_WAIT_REL;
                S_WAIT_REL: begin
                    if (!play) begin
                        state_nx = S_IDLE;
                    end
                end
                S_OVER:     state_nx = S_OVER;
                default:    state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            lfsr         <= LFSR_SEED;
            play_q       <= 1'b0;
            move_q       <= ROCK;
            mode_q       <= 1'b0;
            prev_move    <= ROCK;
            prev_valid   <= 1'b0;
            com_move     <= ROCK;
            user_score   <= '0;
            com_score    <= '0;
            uwin         <= 1'b0;
            cwin         <= 1'b0;
            draw         <= 1'b0;
            invalid      <= 1'b0;
            result_valid <= 1'b0;
            match_over   <= 1'b0;
            match_winner <= 1'b0;
        end else begin
            lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            play_q       <= play;
            result_valid <= 1'b0;
            if (new_match) begin
                user_score   <= '0;
                com_score    <= '0;
                uwin         <= 1'b0;
                cwin         <= 1'b0;
                draw         <= 1'b0;
                invalid      <= 1'b0;
                match_over   <= 1'b0;
                match_winner <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (play_rise) begin
                            if (user_move == INVALID) begin
                                invalid <= 1'b1;
                                uwin    <= 1'b0;
                                cwin    <= 1'b0;
                                draw    <= 1'b0;
                            end else begin
                                move_q <= user_move;
                                mode_q <= mode;
                            end
                        end
                    end
                    S_DECIDE: com_move <= mode_q ? pred_move : rand_move;
                    S_JUDGE: begin
                        uwin         <= u_wins;
                        cwin         <= c_wins;
                        draw         <= tie;
                        invalid      <= 1'b0;
                        user_score   <= user_nx;
                        com_score    <= com_nx;
                        result_valid <= 1'b1;
                        prev_move    <= move_q;
                        prev_valid   <= 1'b1;
                        if (reach) begin
                            match_over   <= 1'b1;
                            match_winner <= c_wins;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rps_match_engine.sv
// tb/tb_rps_match_engine.sv - self-checking bench for rps_match_engine
module tb_rps_match_engine;

    localparam int          SCORE_W    = 8;
    localparam int          WIN_TARGET = 3;
    localparam int          CNT_W      = 2;
    localparam logic [15:0] SEED       = 16'hACE1;
    localparam int          CMAX       = (1 << CNT_W) - 1;

    logic               CLOCK_50 = 1'b0;
    logic               reset = 1'b0;
    logic               play = 1'b0;
    logic [1:0]         user_move = 2'b00;
    logic               mode = 1'b0;
    logic               new_match = 1'b0;
    logic [1:0]         com_move;
    logic [SCORE_W-1:0] user_score;
    logic [SCORE_W-1:0] com_score;
    logic               uwin, cwin, draw, invalid, result_valid;
    logic               match_over, match_winner, busy;

    rps_match_engine #(
        .SCORE_W   (SCORE_W),
        .WIN_TARGET(WIN_TARGET),
        .CNT_W     (CNT_W),
        .LFSR_SEED (SEED)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .play        (play),
        .user_move   (user_move),
        .mode        (mode),
        .new_match   (new_match),
        .com_move    (com_move),
        .user_score  (user_score),
        .com_score   (com_score),
        .uwin        (uwin),
        .cwin        (cwin),
        .draw        (draw),
        .invalid     (invalid),
        .result_valid(result_valid),
        .match_over  (match_over),
        .match_winner(match_winner),
        .busy        (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    // Reference model: plain integers, moves 0=rock 1=scissors 2=paper.
    logic [15:0] m_lfsr = SEED;
    int m_hist [3][3];
    int m_prev, m_us, m_cs, m_com;
    bit m_prev_valid, m_uwin, m_cwin, m_draw, m_inv, m_over, m_winner;

    typedef struct {
        int mv;
        int com;
        bit uw;
        bit cw;
        bit dr;
        bit inv;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], ^(l & 16'hB400)};
    endfunction

    function automatic int model_rand(input logic [15:0] l);
        int r;
        r = int'(l) % 4;
        if (r == 3) r = (int'(l) >> 2) & 1;
        return r;
    endfunction

    function automatic bit wins(input int a, input int b);
        return ((b - a + 3) % 3) == 1;
    endfunction

    function automatic int model_predict(input int r);
        int best, bc;
        if (!m_prev_valid) return r;
        best = 0;
        bc   = m_hist[m_prev][0];
        for (int j = 1; j < 3; j++) begin
            if (m_hist[m_prev][j] > bc) begin
                bc   = m_hist[m_prev][j];
                best = j;
            end
        end
        if (bc == 0) return r;
        return (best + 2) % 3;
    endfunction

    task automatic model_clear_match();
        m_us = 0; m_cs = 0;
        m_uwin = 0; m_cwin = 0; m_draw = 0; m_inv = 0; m_over = 0; m_winner = 0;
    endtask

    task automatic model_reset();
        model_clear_match();
        m_com = 0; m_prev = 0; m_prev_valid = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                m_hist[i][j] = 0;
    endtask

    task automatic model_judge(input int mv, input int c);
        m_com = c; m_inv = 0;
        m_uwin = 0; m_cwin = 0; m_draw = 0;
        if (mv == c) m_draw = 1;
        else if (wins(mv, c)) begin
            m_uwin = 1;
            if (m_us < WIN_TARGET) m_us++;
            if (m_us == WIN_TARGET) begin m_over = 1; m_winner = 0; end
        end else begin
            m_cwin = 1;
            if (m_cs < WIN_TARGET) m_cs++;
            if (m_cs == WIN_TARGET) begin m_over = 1; m_winner = 1; end
        end
        if (m_prev_valid) begin
            if (m_hist[m_prev][mv] == CMAX)
                for (int j = 0; j < 3; j++) m_hist[m_prev][j] = m_hist[m_prev][j] / 2;
            m_hist[m_prev][mv]++;
        end
        m_prev = mv;
        m_prev_valid = 1;
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        if (!reset) m_lfsr = SEED;
        else        m_lfsr = lfsr_step(m_lfsr);
        @(negedge CLOCK_50);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".com_move"}, com_move, m_com);
        check({tag, ".user_score"}, user_score, m_us);
        check({tag, ".com_score"}, com_score, m_cs);
        check({tag, ".uwin"}, uwin, m_uwin);
        check({tag, ".cwin"}, cwin, m_cwin);
        check({tag, ".draw"}, draw, m_draw);
        check({tag, ".invalid"}, invalid, m_inv);
        check({tag, ".match_over"}, match_over, m_over);
        check({tag, ".match_winner"}, match_winner, m_winner);
    endtask

    task automatic check_all_zero(input string tag);
        check_outputs(tag);
        check({tag, ".result_valid"}, result_valid, 0);
        check({tag, ".busy"}, busy, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0; play = 1'b0; new_match = 1'b0;
        model_reset();
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;
    endtask

    task automatic pulse_new_match();
        new_match = 1'b1;
        tick();
        new_match = 1'b0;
        model_clear_match();
    endtask

    // Idle until the LFSR value seen during DECIDE yields the wanted move.
    task automatic wait_for_rand(input int target);
        int n;
        n = 0;
        while (model_rand(lfsr_step(m_lfsr)) != target && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL wait_for_rand: got none expected move %0d", target);
        end
    endtask

    task automatic do_round(input int mv, input bit md);
        int r;
        user_move = 2'(mv); mode = md; play = 1'b1;
        tick();
        if (mv == 3) begin
            m_inv = 1; m_uwin = 0; m_cwin = 0; m_draw = 0;
            tick();
            check("inv.rv1", result_valid, 0);
            tick();
            check("inv.rv2", result_valid, 0);
            check_outputs("inv");
        end else begin
            r = model_rand(m_lfsr);
            tick();
            check("round.rv_early", result_valid, 0);
            tick();
            check("round.rv", result_valid, 1);
            model_judge(mv, md ? model_predict(r) : r);
            check_outputs("round");
        end
        play = 1'b0;
        tick();
        check("round.rv_pulse", result_valid, 0);
        tick();
    endtask

    initial begin
        int cnt, r;
        int exp_h [5];

        vecs[0] = '{0, 0, 0, 0, 1, 0};
        vecs[1] = '{0, 1, 1, 0, 0, 0};
        vecs[2] = '{0, 2, 0, 1, 0, 0};
        vecs[3] = '{1, 0, 0, 1, 0, 0};
        vecs[4] = '{1, 1, 0, 0, 1, 0};
        vecs[5] = '{1, 2, 1, 0, 0, 0};
        vecs[6] = '{2, 0, 1, 0, 0, 0};
        vecs[7] = '{2, 1, 0, 1, 0, 0};
        vecs[8] = '{2, 2, 0, 0, 1, 0};
        vecs[9] = '{3, 0, 0, 0, 0, 1};
        exp_h = '{0, 1, 2, 3, 2};

        do_reset();

        // Rock against a scissors draw from the LFSR.
        wait_for_rand(1);
        do_round(0, 1'b0);
        check("t1.uwin", uwin, 1);
        check("t1.user_score", user_score, 1);

        // Holding play high yields exactly one round.
        pulse_new_match();
        user_move = 2'd2; mode = 1'b0; play = 1'b1;
        tick();
        r = model_rand(m_lfsr);
        cnt = 0;
        for (int i = 0; i < 21; i++) begin
            tick();
            if (result_valid) cnt++;
        end
        model_judge(2, r);
        check("t2.pulses", cnt, 1);
        check("t2.busy", busy, 1);
        check_outputs("t2");
        play = 1'b0;
        tick();
        tick();

        // Invalid press, then a valid one clears the flag.
        do_round(3, 1'b0);
        do_round(1, 1'b0);
        check("t3.invalid_cleared", invalid, 0);

        for (int v = 0; v < 10; v++) begin
            pulse_new_match();
            if (vecs[v].mv != 3) wait_for_rand(vecs[v].com);
            do_round(vecs[v].mv, 1'b0);
            if (vecs[v].mv != 3) check($sformatf("vec%0d.com", v), com_move, vecs[v].com);
            check($sformatf("vec%0d.uwin", v), uwin, vecs[v].uw);
            check($sformatf("vec%0d.cwin", v), cwin, vecs[v].cw);
            check($sformatf("vec%0d.draw", v), draw, vecs[v].dr);
            check($sformatf("vec%0d.invalid", v), invalid, vecs[v].inv);
        end

        // Adaptive opponent learns a rock-only player; computer takes the match.
        do_reset();
        do_round(0, 1'b1);
        do_round(0, 1'b1);
        pulse_new_match();
        for (int k = 3; k <= 5; k++) begin
            do_round(0, 1'b1);
            check($sformatf("t4.r%0d.com", k), com_move, 2);
            check($sformatf("t4.r%0d.cwin", k), cwin, 1);
        end
        check("t5.match_over", match_over, 1);
        check("t5.match_winner", match_winner, 1);
        check("t5.com_score", com_score, 3);
        play = 1'b1; user_move = 2'd0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (result_valid) cnt++;
        end
        play = 1'b0;
        tick();
        check("t5.ignored_pulses", cnt, 0);
        check("t5.busy", busy, 1);
        check_outputs("t5.ignored");
        pulse_new_match();
        check("t5.cleared_over", match_over, 0);
        check("t5.cleared_score", com_score, 0);
        check_outputs("t5.new_match");
        do_round(0, 1'b1);
        check("t4.r6.com", com_move, 2);
        check("t4.r6.cwin", cwin, 1);

        // Reset during DECIDE, then row halving with 2-bit counters.
        play = 1'b1; user_move = 2'd2; mode = 1'b0;
        tick();
        check("t6.busy_decide", busy, 1);
        reset = 1'b0;
        model_reset();
        tick();
        check_all_zero("t6.reset");
        reset = 1'b1; play = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            pulse_new_match();
            do_round(2, 1'b0);
            check($sformatf("t6.hist%0d", k), dut.u_pred.hist[2][2], exp_h[k]);
        end

        // Randomized rounds against the reference model.
        for (int n = 0; n < 60; n++) begin
            if (m_over || ($urandom_range(0, 7) == 0)) pulse_new_match();
            cnt = $urandom_range(0, 3);
            for (int i = 0; i < cnt; i++) tick();
            do_round(($urandom_range(0, 4) == 0) ? 3 : $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
